m_cpu_clock_gen: RTL and testbench

CPU clock-enable generator for the 4-bit CPU board top level. Takes the raw board clock `CLK1`, a raw push button and two slide switches, and produces a single-cycle `CPU_EN` pulse that advances the CPU by one instruction. It supports manual single-step (one debounced press gives one pulse) and free-run at a switch-selected rate. It also keeps an 8-bit step count for the spare HEX digits.

---
 rtl/m_cpu_board_pkg.sv | 17 +
 rtl/m_debounce.sv | 50 +++++
 rtl/m_cpu_clock_gen.sv | 111 +++++++++++
 tb/tb_m_cpu_clock_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m_cpu_board_pkg.sv
// Shared types and defaults for the 4-bit CPU board clock-enable logic.
package m_cpu_board_pkg;

    typedef enum logic {
        S_STEP = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int unsigned DEBOUNCE_CYC_DEFAULT = 500_000;
    localparam int unsigned RUN_DIV_DEFAULT      = 25_000_000;

    // Free-run period in board clocks for a given speed setting.
    function automatic logic [31:0] run_period(input int unsigned run_div, input logic [1:0] speed);
        return run_div >> {speed, 1'b0};
    endfunction

endpackage

// File: rtl/m_debounce.sv
// Push-button synchroniser and debouncer: emits a stable level and a one-cycle press pulse.
// The level changes only after the synced input differs from it for DEBOUNCE_CYC consecutive cycles.
module m_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync;
    logic             pressed;
    logic [CNT_W-1:0] dcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], btn_n};
        end
    end

    assign pressed = ~sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt  <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (pressed == level) begin
                dcnt <= '0;
            end else if (dcnt == CNT_LAST) begin
                // Only the released->pressed transition produces an event.
                dcnt  <= '0;
                level <= pressed;
                press <= pressed;
            end else begin
                dcnt <= dcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/m_cpu_clock_gen.sv
// CPU clock-enable generator: single-step on debounced press, or free-run at a switch-selected rate.
// Outputs a registered one-cycle CPU_EN pulse and an 8-bit count of pulses issued.
module m_cpu_clock_gen
    import m_cpu_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int unsigned RUN_DIV      = RUN_DIV_DEFAULT
) (
    input  logic       CLK1,
    input  logic       RST,
    input  logic       BTN_N,
    input  logic       MODE,
    input  logic [1:0] SPEED,
    output logic       CPU_EN,
    output logic       BTN_LEVEL,
    output logic       RUNNING,
    output logic [7:0] STEP_CNT
);

    localparam int unsigned DIV_W = $clog2(RUN_DIV);

    logic [1:0]       mode_sync;
    logic [1:0]       speed_sync1;
    logic [1:0]       speed_sync2;
    logic             mode_s;
    logic             press;
    logic [31:0]      period;
    logic [DIV_W-1:0] div_last;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic             en_next;

    m_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk   (CLK1),
        .rst   (RST),
        .btn_n (BTN_N),
        .level (BTN_LEVEL),
        .press (press)
    );

    always_ff @(posedge CLK1 or posedge RST) begin
        if (RST) begin
            mode_sync   <= 2'b00;
            speed_sync1 <= 2'b00;
            speed_sync2 <= 2'b00;
        end else begin
            mode_sync   <= {mode_sync[0], MODE};
            speed_sync1 <= SPEED;
            speed_sync2 <= speed_sync1;
        end
    end

    assign mode_s   = mode_sync[1];
    assign period   = run_period(RUN_DIV, speed_sync2);
    assign div_last = DIV_W'(period - 32'd1);

    always_ff @(posedge CLK1 or posedge RST) begin
        if (RST) begin
            state    <= S_STEP;
            div      <= '0;
            CPU_EN   <= 1'b0;
            STEP_CNT <= 8'd0;
        end else begin
            state    <= state_next;
            div      <= div_next;
            CPU_EN   <= en_next;
            STEP_CNT <= STEP_CNT + {7'd0, en_next};
        end
    end

    // A mode change wins over any pulse due in the same cycle; the ~CPU_EN
    // term keeps pulses apart even when the period collapses to one cycle.
    always_comb begin
        state_next = state;
        div_next   = div;
        en_next    = 1'b0;
        case (state)
            S_STEP: begin
                div_next = '0;
                if (mode_s) begin
                    state_next = S_RUN;
                end else begin
                    en_next = press & ~CPU_EN;
                end
            end
            S_RUN: begin
                if (!mode_s) begin
                    state_next = S_STEP;
                    div_next   = '0;
                end else if (div >= div_last) begin
                    div_next = '0;
                    en_next  = ~CPU_EN;
                end else begin
                    div_next = div + DIV_W'(1);
                end
            end
            default: begin
                state_next = S_STEP;
                div_next   = '0;
            end
        endcase
    end

    assign RUNNING = (state == S_RUN);

endmodule

// File: tb/tb_m_cpu_clock_gen.sv
// Directed bench for m_cpu_clock_gen with DEBOUNCE_CYC=4 and RUN_DIV=64.
module tb_m_cpu_clock_gen;
    import m_cpu_board_pkg::*;

    localparam int unsigned DEB  = 4;
    localparam int unsigned RDIV = 64;
    localparam logic        RUN_ON = S_RUN;

    typedef struct {
        logic       btn_n;
        logic       exp_level;
        logic       exp_en;
        logic [7:0] exp_cnt;
        logic       exp_run;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_n;
    logic       mode;
    logic [1:0] speed;
    logic       cpu_en;
    logic       btn_level;
    logic       running;
    logic [7:0] step_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    vec_t vec [1:30];

    always #5 clk = ~clk;

    m_cpu_clock_gen #(
        .DEBOUNCE_CYC (DEB),
        .RUN_DIV      (RDIV)
    ) dut (
        .CLK1      (clk),
        .RST       (rst),
        .BTN_N     (btn_n),
        .MODE      (mode),
        .SPEED     (speed),
        .CPU_EN    (cpu_en),
        .BTN_LEVEL (btn_level),
        .RUNNING   (running),
        .STEP_CNT  (step_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_en"},    {31'd0, cpu_en},    32'd0);
        check({name, "_level"}, {31'd0, btn_level}, 32'd0);
        check({name, "_run"},   {31'd0, running},   32'd0);
        check({name, "_cnt"},   {24'd0, step_cnt},  32'd0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        btn_n = 1'b1;
        mode  = 1'b0;
        speed = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #3;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_pulse(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (cpu_en) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL pulse_timeout after edge %0d: got no CPU_EN, expected one within %0d cycles", cyc, limit);
        end
    endtask

    initial begin
        int p, q, n, prev_en, viol;

        rst   = 1'b1;
        btn_n = 1'b1;
        mode  = 1'b0;
        speed = 2'd0;

        // Clean press: BTN_N low sampled from edge 10 to 19, released from edge 20.
        for (int e = 1; e <= 30; e++) begin
            vec[e].btn_n     = (e >= 10 && e <= 19) ? 1'b0 : 1'b1;
            vec[e].exp_level = (e >= 15 && e <= 24) ? 1'b1 : 1'b0;
            vec[e].exp_en    = (e == 16) ? 1'b1 : 1'b0;
            vec[e].exp_cnt   = (e >= 16) ? 8'd1 : 8'd0;
            vec[e].exp_run   = 1'b0;
        end

        do_reset();
        for (int e = 1; e <= 30; e++) begin
            btn_n = vec[e].btn_n;
            step();
            check("press_level", {31'd0, btn_level}, {31'd0, vec[e].exp_level});
            check("press_en",    {31'd0, cpu_en},    {31'd0, vec[e].exp_en});
            check("press_cnt",   {24'd0, step_cnt},  {24'd0, vec[e].exp_cnt});
            check("press_run",   {31'd0, running},   {31'd0, vec[e].exp_run});
        end

        // Bounce: 5 x (3 low, 2 high), then held low.
        do_reset();
        n = 0;
        q = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 5; k++) begin
                btn_n = (k < 3) ? 1'b0 : 1'b1;
                step();
                if (cpu_en) n++;
                if (btn_level) q++;
            end
        end
        check("bounce_level_during", q, 0);
        btn_n = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (cpu_en) n++;
        end
        check("bounce_pulses", n, 1);
        check("bounce_cnt", {24'd0, step_cnt}, 1);
        check("bounce_level", {31'd0, btn_level}, 1);

        // Run at SPEED=0: first pulse 2 sync edges + 1 state edge + 64 cycles later.
        do_reset();
        mode = 1'b1;
        wait_pulse(100, p);
        check("run_first_edge", p, 67);
        check("run_running", {31'd0, running}, {31'd0, RUN_ON});
        step();
        check("run_pulse_width", {31'd0, cpu_en}, 0);
        for (int k = 0; k < 3; k++) begin
            wait_pulse(100, q);
            check("run_period64", q - p, 64);
            p = q;
        end
        check("run_cnt4", {24'd0, step_cnt}, 4);

        // SPEED 0->2 with div=30: new last value is 3, so the wrap happens at once.
        repeat (30) step();
        speed = 2'd2;
        wait_pulse(10, q);
        check("speed_change_wrap", q - p, 33);
        p = q;
        for (int k = 0; k < 3; k++) begin
            wait_pulse(20, q);
            check("run_period4", q - p, 4);
            p = q;
        end

        // Back to SPEED=0, then drop MODE with div=30.
        speed = 2'd0;
        wait_pulse(100, p);
        check("cnt_before_mode", {24'd0, step_cnt}, 9);
        repeat (30) step();
        mode = 1'b0;
        n = 0;
        step();
        if (cpu_en) n++;
        step();
        if (cpu_en) n++;
        check("mode_run_edge2", {31'd0, running}, 1);
        step();
        if (cpu_en) n++;
        check("mode_run_edge3", {31'd0, running}, 0);
        for (int k = 0; k < 100; k++) begin
            step();
            if (cpu_en) n++;
        end
        check("mode_no_pulse", n, 0);
        check("mode_cnt_held", {24'd0, step_cnt}, 9);
        n = 0;
        btn_n = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (cpu_en) n++;
        end
        btn_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (cpu_en) n++;
        end
        check("step_after_run", n, 1);
        check("step_after_run_cnt", {24'd0, step_cnt}, 10);

        // Counter wrap: 256 pulses at period 4.
        do_reset();
        mode    = 1'b1;
        speed   = 2'd2;
        n       = 0;
        prev_en = 0;
        viol    = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (cpu_en && prev_en != 0) viol++;
            prev_en = cpu_en ? 1 : 0;
            if (cpu_en) n++;
            if (n == 256) break;
        end
        check("wrap_pulses", n, 256);
        check("wrap_cnt0", {24'd0, step_cnt}, 0);
        check("no_back_to_back", viol, 0);
        wait_pulse(20, q);
        check("wrap_cnt1", {24'd0, step_cnt}, 1);

        // Reset mid-operation with div=40 and dcnt=2.
        do_reset();
        mode = 1'b1;
        wait_pulse(100, p);
        repeat (36) step();
        btn_n = 1'b0;
        repeat (4) step();
        check("pre_reset_run", {31'd0, running}, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        do_reset();
        n = 0;
        for (int k = 0; k < 120; k++) begin
            step();
            if (cpu_en) n++;
        end
        check("post_reset_no_pulse", n, 0);
        check("post_reset_cnt", {24'd0, step_cnt}, 0);
        check("post_reset_level", {31'd0, btn_level}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
